alu_sequencer: RTL and testbench

- Issue/writeback controller that sits on the operand/opcode side of the 8-bit combinational ALU: A, B, 3-bit OPCode in, 8-bit result out.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands from a 4 x 8-bit register file.
- Drives the ALU inputs from registers, captures the ALU result one cycle later, writes it back to the register file and reports it on a result strobe.

---
 rtl/alu_sequencer.sv | 112 +++++++++++
 tb/tb_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Issue/writeback controller for an external 8-bit combinational
//            ALU. It accepts one instruction per three cycles, reads operands
//            from a 4-entry register file, and registers them onto the ALU
//            inputs. One cycle later it writes the ALU result back to the
//            register file and reports it on a one-cycle result strobe.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [15:0]       instr_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [2:0]        alu_op_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              res_valid_o,
  output logic [DATA_W-1:0] res_o,
  output logic [1:0]        res_rd_o,
  input  logic [1:0]        dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  // A load-immediate is issued to the ALU as a plain pass-through of B
  localparam logic [2:0] c_OP_PASSB = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_rd;
  logic [DATA_W-1:0] r_rf [NREG];

  // Instruction field decode
  logic [2:0]        w_opc;
  logic              w_li;
  logic [1:0]        w_rd;
  logic [1:0]        w_ra;
  logic [1:0]        w_rb;
  logic [DATA_W-1:0] w_imm;

  assign w_opc = instr_i[15:13];
  assign w_li  = instr_i[12];
  assign w_rd  = instr_i[11:10];
  assign w_ra  = instr_i[9:8];
  assign w_rb  = instr_i[7:6];
  assign w_imm = instr_i[DATA_W-1:0];

  // Ready depends only on the state, so valid can never combinationally loop back into it
  assign instr_ready_o = (r_state == S_IDLE);

  // Debug read port is a plain asynchronous read of the register file
  assign dbg_data_o = r_rf[dbg_sel_i];

  // Sequencer FSM with the register file and all of its registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd        <= 2'd0;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      alu_op_o    <= 3'b000;
      res_o       <= '0;
      res_rd_o    <= 2'd0;
      res_valid_o <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          res_valid_o <= 1'b0;
          if (instr_valid_i) begin
            alu_op_o <= w_li ? c_OP_PASSB : w_opc;
            alu_a_o  <= r_rf[w_ra];
            alu_b_o  <= w_li ? w_imm : r_rf[w_rb];
            r_rd     <= w_rd;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The ALU has had a full cycle to settle on the registered operands
          r_rf[r_rd]  <= alu_result_i;
          res_o       <= alu_result_i;
          res_rd_o    <= r_rd;
          res_valid_o <= 1'b1;
          r_state     <= S_WB;
        end
        S_WB: begin
          res_valid_o <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          res_valid_o <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. It provides the external
//            ALU, keeps an architectural model of the register file, and
//            exercises directed vectors, a handshake stall, resets, and
//            random instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [15:0] instr_i = 16'h0000;
  logic [7:0]  alu_a_o, alu_b_o, alu_result_i, res_o, dbg_data_o;
  logic [2:0]  alu_op_o;
  logic        res_valid_o;
  logic [1:0]  res_rd_o;
  logic [1:0]  dbg_sel_i = 2'd0;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  logic [7:0] m_rf [4];

  alu_sequencer #(.DATA_W(8), .NREG(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .instr_i      (instr_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_op_o     (alu_op_o),
    .alu_result_i (alu_result_i),
    .res_valid_o  (res_valid_o),
    .res_o        (res_o),
    .res_rd_o     (res_rd_o),
    .dbg_sel_i    (dbg_sel_i),
    .dbg_data_o   (dbg_data_o)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    case (alu_op_o)
      3'b000:  alu_result_i = alu_a_o;
      3'b001:  alu_result_i = alu_b_o;
      3'b010:  alu_result_i = alu_a_o ^ alu_b_o;
      3'b011:  alu_result_i = ~(alu_a_o ^ alu_b_o);
      3'b100:  alu_result_i = alu_a_o + alu_b_o;
      3'b101:  alu_result_i = alu_a_o - alu_b_o;
      3'b110:  alu_result_i = {alu_a_o[6:0], 1'b0};
      default: alu_result_i = {1'b0, alu_a_o[7:1]};
    endcase
  end

  // Count result strobes seen on falling edges
  always @(negedge clk) if (res_valid_o === 1'b1) pulses++;

  // Reference result from the opcode rules using integer arithmetic
  function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a;
      1: r = b;
      2: r = a ^ b;
      3: r = 255 - (a ^ b);
      4: r = (a + b) % 256;
      5: r = (a - b + 256) % 256;
      6: r = (a * 2) % 256;
      default: r = a / 2;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [15:0] mk_r(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb);
    return {op, 1'b0, rd, ra, rb, 6'b0};
  endfunction

  // The opcode field is deliberately non-zero to show that it is ignored for a load-immediate
  function automatic logic [15:0] mk_li(input logic [1:0] rd, input logic [7:0] imm);
    return {3'b110, 1'b1, rd, imm[7:6] ^ 2'b11, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
  endtask

  // Issue one instruction and check it through EXEC, WB and back to IDLE
  task automatic issue(input logic [15:0] ins, input bit use_tab, input logic [7:0] tab_exp,
                       input bit keep_valid, input logic [15:0] next_ins);
    logic [2:0] e_op;
    logic [7:0] e_a, e_b, e_res;
    logic [1:0] rd;
    int         wait_cnt;
    rd    = ins[11:10];
    e_op  = ins[12] ? 3'd1 : ins[15:13];
    e_a   = m_rf[ins[9:8]];
    e_b   = ins[12] ? ins[7:0] : m_rf[ins[7:6]];
    e_res = ref_alu(int'(e_op), int'(e_a), int'(e_b));
    wait_cnt = 0;
    while (instr_ready_o !== 1'b1 && wait_cnt < 10) begin
      step();
      wait_cnt++;
    end
    chk("ready_idle", instr_ready_o, 1);
    instr_i       = ins;
    instr_valid_i = 1'b1;
    dbg_sel_i     = rd;
    step();
    // EXEC
    instr_valid_i = keep_valid;
    instr_i       = keep_valid ? next_ins : 16'($urandom);
    chk("ready_exec", instr_ready_o, 0);
    chk("alu_op", alu_op_o, e_op);
    chk("alu_a", alu_a_o, e_a);
    chk("alu_b", alu_b_o, e_b);
    chk("res_valid_exec", res_valid_o, 0);
    step();
    // WB
    chk("res_valid_wb", res_valid_o, 1);
    chk("res", res_o, e_res);
    chk("res_rd", res_rd_o, rd);
    chk("dbg_wb", dbg_data_o, e_res);
    chk("ready_wb", instr_ready_o, 0);
    if (use_tab) chk("tab_res", res_o, tab_exp);
    m_rf[rd] = e_res;
    step();
    // Back in IDLE, ALU operands held
    chk("res_valid_idle", res_valid_o, 0);
    chk("ready_back", instr_ready_o, 1);
    chk("alu_op_hold", alu_op_o, e_op);
    chk("alu_a_hold", alu_a_o, e_a);
  endtask

  task automatic chk_all_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_sel_i = 2'(i);
      #1;
      chk(name, dbg_data_o, m_rf[i]);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int p0;
    logic [15:0] s0, s1, s2;

    vecs[0]  = '{mk_li(2'd0, 8'h3C), 8'h3C};
    vecs[1]  = '{mk_li(2'd1, 8'hC8), 8'hC8};
    vecs[2]  = '{mk_r(3'b100, 2'd2, 2'd0, 2'd1), 8'h04};
    vecs[3]  = '{mk_li(2'd0, 8'h05), 8'h05};
    vecs[4]  = '{mk_li(2'd1, 8'h07), 8'h07};
    vecs[5]  = '{mk_r(3'b101, 2'd3, 2'd0, 2'd1), 8'hFE};
    vecs[6]  = '{mk_li(2'd0, 8'hA5), 8'hA5};
    vecs[7]  = '{mk_li(2'd1, 8'h0F), 8'h0F};
    vecs[8]  = '{mk_r(3'b010, 2'd2, 2'd0, 2'd1), 8'hAA};
    vecs[9]  = '{mk_r(3'b011, 2'd3, 2'd0, 2'd1), 8'h55};
    vecs[10] = '{mk_li(2'd0, 8'h81), 8'h81};
    vecs[11] = '{mk_r(3'b110, 2'd0, 2'd0, 2'd0), 8'h02};
    vecs[12] = '{mk_r(3'b111, 2'd0, 2'd0, 2'd0), 8'h01};
    vecs[13] = '{mk_r(3'b000, 2'd1, 2'd0, 2'd3), 8'h01};

    model_reset();
    // Power-on reset with a stray valid that must not be taken
    instr_valid_i = 1'b1;
    instr_i       = mk_li(2'd2, 8'h77);
    step();
    step();
    chk("rst_ready", instr_ready_o, 1);
    chk("rst_res_valid", res_valid_o, 0);
    instr_valid_i = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", instr_ready_o, 1);
    chk_all_regs("rst_rf");

    // Directed vectors
    for (int i = 0; i < 14; i++) issue(vecs[i].ins, 1'b1, vecs[i].exp, 1'b0, 16'h0);
    chk_all_regs("dir_rf");

    // Handshake stall: valid stays high across three back-to-back instructions
    s0 = mk_r(3'b100, 2'd2, 2'd0, 2'd1);
    s1 = mk_r(3'b101, 2'd3, 2'd2, 2'd0);
    s2 = mk_r(3'b010, 2'd1, 2'd3, 2'd2);
    p0 = pulses;
    issue(s0, 1'b0, 8'h0, 1'b1, s1);
    issue(s1, 1'b0, 8'h0, 1'b1, s2);
    issue(s2, 1'b0, 8'h0, 1'b0, 16'h0);
    step();
    chk("stall_pulses", pulses - p0, 3);
    chk("stall_no_reissue", instr_ready_o, 1);
    chk_all_regs("stall_rf");

    // Reset mid-run in IDLE
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_a", alu_a_o, 0);
    chk("mrst_b", alu_b_o, 0);
    chk("mrst_op", alu_op_o, 0);
    chk("mrst_res", res_o, 0);
    chk("mrst_rd", res_rd_o, 0);
    chk("mrst_ready", instr_ready_o, 1);
    chk_all_regs("mrst_rf");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_pulses", pulses - p0, 0);

    // Reset during EXEC discards the in-flight ADD
    issue(mk_li(2'd0, 8'h10), 1'b1, 8'h10, 1'b0, 16'h0);
    instr_i       = mk_r(3'b100, 2'd1, 2'd0, 2'd0);
    instr_valid_i = 1'b1;
    step();
    instr_valid_i = 1'b0;
    chk("erst_in_exec", instr_ready_o, 0);
    p0 = pulses;
    rst_n = 1'b0;
    model_reset();
    step();
    chk("erst_res_valid", res_valid_o, 0);
    rst_n = 1'b1;
    step();
    chk("erst_ready", instr_ready_o, 1);
    chk("erst_pulses", pulses - p0, 0);
    chk_all_regs("erst_rf");

    // Random instructions with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      issue(16'($urandom), 1'b0, 8'h0, 1'b0, 16'h0);
    end
    chk_all_regs("rand_rf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
